// File: rtl/report_drain.sv
// Consumer end of the automaton report interface: timestamps non-zero report
// vectors, buffers them, and serializes one (offset, report_id) record per set bit.
module report_drain #(
  parameter int unsigned NUM_REPORTS  = 8,
  parameter int unsigned OFFSET_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           symbol_valid,
  input  logic [NUM_REPORTS-1:0]         report_vector,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [OFFSET_WIDTH-1:0]        out_offset,
  output logic [$clog2(NUM_REPORTS)-1:0] out_report_id,
  output logic                           overflow,
  output logic [15:0]                    dropped_count
);

  localparam int unsigned IDW = $clog2(NUM_REPORTS);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned EW  = OFFSET_WIDTH + NUM_REPORTS;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t                  r_state;
  logic [OFFSET_WIDTH-1:0] r_offset;
  logic [EW-1:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [NUM_REPORTS-1:0]  r_mask;
  logic                    r_valid;
  logic [OFFSET_WIDTH-1:0] r_out_offset;
  logic [IDW-1:0]          r_out_id;
  logic                    r_overflow;
  logic [15:0]             r_dropped;

  logic                    w_hs;
  logic [NUM_REPORTS-1:0]  w_mask_rest;
  logic                    w_pop;
  logic                    w_push_req;
  logic                    w_full;
  logic                    w_push;
  logic                    w_drop;
  logic [EW-1:0]           w_push_entry;
  logic                    w_load;
  logic [EW-1:0]           w_next_entry;
  logic [OFFSET_WIDTH-1:0] w_next_off;
  logic [NUM_REPORTS-1:0]  w_next_vec;

  function automatic logic [IDW-1:0] f_lsb(input logic [NUM_REPORTS-1:0] v);
    f_lsb = '0;
    for (int unsigned i = 0; i < NUM_REPORTS; i++) begin
      if (v[NUM_REPORTS-1-i]) f_lsb = IDW'(NUM_REPORTS-1-i);
    end
  endfunction

  assign w_hs         = r_valid & out_ready;
  assign w_mask_rest  = r_mask & (r_mask - NUM_REPORTS'(1));
  assign w_pop        = w_hs && (w_mask_rest == '0);
  assign w_push_req   = symbol_valid && (report_vector != '0);
  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_push       = w_push_req && (!w_full || w_pop);
  assign w_drop       = w_push_req && w_full && !w_pop;
  assign w_push_entry = {r_offset, report_vector};

  // The head stays in the FIFO until its last record retires; when the FIFO
  // would otherwise be empty the incoming entry is forwarded straight to the head.
  always_comb begin
    w_load       = 1'b0;
    w_next_entry = '0;
    if (r_state == ST_IDLE) begin
      if (w_push) begin
        w_load       = 1'b1;
        w_next_entry = w_push_entry;
      end
    end else if (w_pop) begin
      if (r_count >= CW'(2)) begin
        w_load       = 1'b1;
        w_next_entry = r_mem[r_rd_ptr + PW'(1)];
      end else if (w_push) begin
        w_load       = 1'b1;
        w_next_entry = w_push_entry;
      end
    end
  end

  assign w_next_off = w_next_entry[EW-1 -: OFFSET_WIDTH];
  assign w_next_vec = w_next_entry[NUM_REPORTS-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_offset     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_mask       <= '0;
      r_valid      <= 1'b0;
      r_out_offset <= '0;
      r_out_id     <= '0;
      r_overflow   <= 1'b0;
      r_dropped    <= '0;
    end else begin
      if (symbol_valid) r_offset <= r_offset + OFFSET_WIDTH'(1);
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
      end
      if (w_load) begin
        r_state      <= ST_EMIT;
        r_valid      <= 1'b1;
        r_mask       <= w_next_vec;
        r_out_offset <= w_next_off;
        r_out_id     <= f_lsb(w_next_vec);
      end else if (w_pop) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
        r_mask  <= '0;
      end else if (w_hs) begin
        r_mask   <= w_mask_rest;
        r_out_id <= f_lsb(w_mask_rest);
      end
    end
  end

  assign out_valid     = r_valid;
  assign out_offset    = r_out_offset;
  assign out_report_id = r_out_id;
  assign overflow      = r_overflow;
  assign dropped_count = r_dropped;

endmodule

// File: tb/tb_report_drain.sv
// Directed bench for report_drain: default instance plus a 4-bit offset
// instance sharing the same stimulus for the wrap scenario.
module tb_report_drain;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        symbol_valid = 1'b0;
  logic [7:0]  report_vector = '0;
  logic        out_ready = 1'b0;

  logic        o1_valid;
  logic [31:0] o1_offset;
  logic [2:0]  o1_id;
  logic        o1_ovf;
  logic [15:0] o1_drop;

  logic        o2_valid;
  logic [3:0]  o2_offset;
  logic [2:0]  o2_id;
  logic        o2_ovf;
  logic [15:0] o2_drop;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  report_drain #(.NUM_REPORTS(8), .OFFSET_WIDTH(32), .FIFO_DEPTH(16)) dut1 (
    .clock(clock), .reset(reset), .symbol_valid(symbol_valid),
    .report_vector(report_vector), .out_ready(out_ready),
    .out_valid(o1_valid), .out_offset(o1_offset), .out_report_id(o1_id),
    .overflow(o1_ovf), .dropped_count(o1_drop));

  report_drain #(.NUM_REPORTS(8), .OFFSET_WIDTH(4), .FIFO_DEPTH(16)) dut2 (
    .clock(clock), .reset(reset), .symbol_valid(symbol_valid),
    .report_vector(report_vector), .out_ready(out_ready),
    .out_valid(o2_valid), .out_offset(o2_offset), .out_report_id(o2_id),
    .overflow(o2_ovf), .dropped_count(o2_drop));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; symbol_valid = 1'b0; report_vector = '0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; symbol_valid = 1'b1; report_vector = 8'hFF; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", o1_valid); end
    n_cmp++; if (o1_offset !== 32'd0 || o1_id !== 3'd0) begin n_fail++; $display("FAIL reset_rec: got (%0d,%0d) want (0,0)", o1_offset, o1_id); end
    n_cmp++; if (o1_ovf !== 1'b0 || o1_drop !== 16'd0) begin n_fail++; $display("FAIL reset_flags: got ovf=%0b drop=%0d want 0/0", o1_ovf, o1_drop); end
    reset = 1'b0; symbol_valid = 1'b0; report_vector = '0;
  endtask

  task automatic test_single_bit();
    do_reset();
    out_ready = 1'b1; symbol_valid = 1'b1;
    report_vector = 8'h00; tick();
    report_vector = 8'h00; tick();
    report_vector = 8'h04; tick();
    n_cmp++; if (o1_valid !== 1'b1 || o1_offset !== 32'd2 || o1_id !== 3'd2) begin n_fail++; $display("FAIL single_rec: got v=%0b (%0d,%0d) want v=1 (2,2)", o1_valid, o1_offset, o1_id); end
    report_vector = 8'h00; tick();
    n_cmp++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL single_done: got valid=%0b want 0", o1_valid); end
    symbol_valid = 1'b0; tick();
    n_cmp++; if (o1_valid !== 1'b0 || o1_ovf !== 1'b0) begin n_fail++; $display("FAIL single_idle: got v=%0b ovf=%0b want 0/0", o1_valid, o1_ovf); end
  endtask

  task automatic test_multi_bit();
    logic [2:0] exp_ids [3] = '{3'd1, 3'd4, 3'd7};
    do_reset();
    out_ready = 1'b1; symbol_valid = 1'b1; report_vector = 8'b1001_0010;
    tick();
    symbol_valid = 1'b0; report_vector = '0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (o1_valid !== 1'b1 || o1_offset !== 32'd0 || o1_id !== exp_ids[i]) begin n_fail++; $display("FAIL multi_rec%0d: got v=%0b (%0d,%0d) want v=1 (0,%0d)", i, o1_valid, o1_offset, o1_id, exp_ids[i]); end
      tick();
    end
    n_cmp++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL multi_done: got valid=%0b want 0", o1_valid); end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_ids [3] = '{3'd1, 3'd4, 3'd7};
    do_reset();
    out_ready = 1'b0; symbol_valid = 1'b1; report_vector = 8'b1001_0010;
    tick();
    symbol_valid = 1'b0; report_vector = '0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (o1_valid !== 1'b1 || o1_offset !== 32'd0 || o1_id !== 3'd1) begin n_fail++; $display("FAIL bp_hold%0d: got v=%0b (%0d,%0d) want v=1 (0,1)", i, o1_valid, o1_offset, o1_id); end
      if (i < 4) tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (o1_valid !== 1'b1 || o1_id !== exp_ids[i]) begin n_fail++; $display("FAIL bp_rec%0d: got v=%0b id=%0d want v=1 id=%0d", i, o1_valid, o1_id, exp_ids[i]); end
      tick();
    end
    n_cmp++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done: got valid=%0b want 0", o1_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0; symbol_valid = 1'b1; report_vector = 8'h01;
    for (int i = 0; i < 20; i++) tick();
    symbol_valid = 1'b0; report_vector = '0;
    n_cmp++; if (o1_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", o1_ovf); end
    n_cmp++; if (o1_drop !== 16'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", o1_drop); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (o1_valid !== 1'b1 || o1_offset !== 32'(i) || o1_id !== 3'd0) begin n_fail++; $display("FAIL ovf_drain%0d: got v=%0b (%0d,%0d) want v=1 (%0d,0)", i, o1_valid, o1_offset, o1_id, i); end
      tick();
    end
    n_cmp++; if (o1_valid !== 1'b0 || o1_ovf !== 1'b1 || o1_drop !== 16'd4) begin n_fail++; $display("FAIL ovf_after: got v=%0b ovf=%0b drop=%0d want 0/1/4", o1_valid, o1_ovf, o1_drop); end
    do_reset();
    n_cmp++; if (o1_ovf !== 1'b0 || o1_drop !== 16'd0) begin n_fail++; $display("FAIL ovf_clear: got ovf=%0b drop=%0d want 0/0", o1_ovf, o1_drop); end
  endtask

  task automatic test_full_pop();
    do_reset();
    out_ready = 1'b0; symbol_valid = 1'b1; report_vector = 8'h01;
    for (int i = 0; i < 16; i++) tick();
    out_ready = 1'b1; report_vector = 8'h80;
    tick();
    symbol_valid = 1'b0; report_vector = '0;
    n_cmp++; if (o1_ovf !== 1'b0 || o1_drop !== 16'd0) begin n_fail++; $display("FAIL fullpop_flags: got ovf=%0b drop=%0d want 0/0", o1_ovf, o1_drop); end
    for (int i = 1; i < 16; i++) begin
      n_cmp++; if (o1_valid !== 1'b1 || o1_offset !== 32'(i) || o1_id !== 3'd0) begin n_fail++; $display("FAIL fullpop_rec%0d: got v=%0b (%0d,%0d) want v=1 (%0d,0)", i, o1_valid, o1_offset, o1_id, i); end
      tick();
    end
    n_cmp++; if (o1_valid !== 1'b1 || o1_offset !== 32'd16 || o1_id !== 3'd7) begin n_fail++; $display("FAIL fullpop_last: got v=%0b (%0d,%0d) want v=1 (16,7)", o1_valid, o1_offset, o1_id); end
    tick();
    n_cmp++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_done: got valid=%0b want 0", o1_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1; symbol_valid = 1'b1; report_vector = 8'h01;
    tick();
    n_cmp++; if (o1_valid !== 1'b1 || o1_offset !== 32'd0 || o1_id !== 3'd0) begin n_fail++; $display("FAIL b2b_first: got v=%0b (%0d,%0d) want v=1 (0,0)", o1_valid, o1_offset, o1_id); end
    report_vector = 8'h06;
    tick();
    symbol_valid = 1'b0; report_vector = '0;
    n_cmp++; if (o1_valid !== 1'b1 || o1_offset !== 32'd1 || o1_id !== 3'd1) begin n_fail++; $display("FAIL b2b_second: got v=%0b (%0d,%0d) want v=1 (1,1)", o1_valid, o1_offset, o1_id); end
    tick();
    n_cmp++; if (o1_valid !== 1'b1 || o1_offset !== 32'd1 || o1_id !== 3'd2) begin n_fail++; $display("FAIL b2b_third: got v=%0b (%0d,%0d) want v=1 (1,2)", o1_valid, o1_offset, o1_id); end
    tick();
    n_cmp++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got valid=%0b want 0", o1_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      symbol_valid = 1'b1;
      report_vector = (i == 17) ? 8'h20 : 8'h00;
      tick();
    end
    symbol_valid = 1'b0; report_vector = '0;
    n_cmp++; if (o2_valid !== 1'b1 || o2_offset !== 4'd1 || o2_id !== 3'd5) begin n_fail++; $display("FAIL wrap_rec: got v=%0b (%0d,%0d) want v=1 (1,5)", o2_valid, o2_offset, o2_id); end
    n_cmp++; if (o1_offset !== 32'd17) begin n_fail++; $display("FAIL wrap_wide: got %0d want 17", o1_offset); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; symbol_valid = 1'b1; report_vector = 8'h03;
    tick(); tick(); tick();
    symbol_valid = 1'b0; report_vector = '0;
    n_cmp++; if (o1_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got valid=%0b want 1", o1_valid); end
    reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (o1_valid !== 1'b0 || o1_offset !== 32'd0 || o1_id !== 3'd0) begin n_fail++; $display("FAIL rmid_clear: got v=%0b (%0d,%0d) want v=0 (0,0)", o1_valid, o1_offset, o1_id); end
    n_cmp++; if (o1_ovf !== 1'b0 || o1_drop !== 16'd0) begin n_fail++; $display("FAIL rmid_flags: got ovf=%0b drop=%0d want 0/0", o1_ovf, o1_drop); end
    tick();
    n_cmp++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got valid=%0b want 0", o1_valid); end
    symbol_valid = 1'b1; report_vector = 8'h02;
    tick();
    symbol_valid = 1'b0; report_vector = '0;
    n_cmp++; if (o1_valid !== 1'b1 || o1_offset !== 32'd0 || o1_id !== 3'd1) begin n_fail++; $display("FAIL rmid_new: got v=%0b (%0d,%0d) want v=1 (0,1)", o1_valid, o1_offset, o1_id); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_multi_bit();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
